// File: rtl/reg_access_arbiter_if.sv
// Bus between requesters and the shared-register arbiter.
// Requesters drive req/wdata; the arbiter returns grant, the write pulse and register state.
interface reg_access_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Handshake: req[i] is a level held until ack is seen with q_owner == i;
    // gnt is a one-cycle registered offer, ack a one-cycle pulse once q holds the data.
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic           ack;
    logic [W-1:0]   q;
    logic [IW-1:0]  q_owner;
    logic           busy;
    logic [7:0]     wcount;

    modport master (
        output req, wdata,
        input  gnt, ack, q, q_owner, busy, wcount
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, q, q_owner, busy, wcount
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared W-bit register.
// Each write takes three cycles: GRANT offer, write with ack in RELEASE, back to IDLE.
module reg_access_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_access_arbiter_if.slave    bus,
    output logic [1:0]             fsm_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [N-1:0]    gnt, gnt_n;
    logic            ack, ack_n;
    logic [W-1:0]    q, q_n;
    logic [IW-1:0]   owner, owner_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   win, win_n;
    logic [IW-1:0]   pick;
    logic [7:0]      wcount, wcount_n;

    // Scan from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        pick = '0;
        for (int k = N; k >= 1; k--) begin
            if (bus.req[(int'(ptr) + k) % N]) pick = IW'((int'(ptr) + k) % N);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= '0;
            ack    <= 1'b0;
            q      <= '0;
            owner  <= '0;
            ptr    <= IW'(N - 1);
            win    <= '0;
            wcount <= 8'd0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            ack    <= ack_n;
            q      <= q_n;
            owner  <= owner_n;
            ptr    <= ptr_n;
            win    <= win_n;
            wcount <= wcount_n;
        end
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        ack_n    = ack;
        q_n      = q;
        owner_n  = owner;
        ptr_n    = ptr;
        win_n    = win;
        wcount_n = wcount;
        case (state)
            IDLE: begin
                ack_n = 1'b0;
                if (|bus.req) begin
                    win_n   = pick;
                    gnt_n   = N'(1) << pick;
                    state_n = GRANT;
                end else begin
                    gnt_n = '0;
                end
            end
            GRANT: begin
                gnt_n = '0;
                // A winner that dropped its request forfeits the slot without writing.
                if (bus.req[win]) begin
                    q_n      = bus.wdata[int'(win) * W +: W];
                    owner_n  = win;
                    ack_n    = 1'b1;
                    ptr_n    = win;
                    wcount_n = 8'(wcount + 8'd1);
                    state_n  = RELEASE;
                end else begin
                    state_n = IDLE;
                end
            end
            RELEASE: begin
                ack_n   = 1'b0;
                gnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                ack_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.gnt     = gnt;
    assign bus.ack     = ack;
    assign bus.q       = q;
    assign bus.q_owner = owner;
    assign bus.busy    = (state != IDLE);
    assign bus.wcount  = wcount;
    assign fsm_state   = state;
endmodule
